// File: rtl/mymuldiv.sv
// Multi-cycle multiply/divide unit next to the EX-stage ALU: pipelined multiplier and
// iterative radix-2 restoring divider behind valid/ready handshakes, one op in flight.
module mymuldiv #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on the rising edge where in_valid && in_ready (and no
  // flush); a result transfers on the rising edge where out_valid && out_ready. The
  // producer holds its payload stable until the transfer edge.

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_RSV   = 3'd7;

  localparam int CNT_MAX = (DATA_W > MUL_STAGES) ? DATA_W : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_PREP = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_FIX  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   quo_q, rem_q, dvs_q;
  logic                q_neg_q, r_neg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [2*DATA_W-1:0] mul_pipe_q [MUL_STAGES];

  logic                accept;
  logic                div_op;
  logic                div_zero;
  logic                mul_signed;
  logic                sgn_op;
  logic [2*DATA_W-1:0] mul_a, mul_b, mul_prod;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     shifted, diff;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic [2*DATA_W-1:0] mul_last;

  assign accept   = in_valid && in_ready && !flush;
  assign div_op   = (op >= OP_DIV) && (op != OP_RSV);
  assign div_zero = div_op && (src2 == '0);

  // Sign-extending both operands to 2*DATA_W makes the low 2*DATA_W bits of an
  // unsigned product equal to the signed product, so one array serves MULH and MULHU.
  assign mul_signed = (op == OP_MULH);
  assign mul_a      = {{DATA_W{mul_signed & src1[DATA_W-1]}}, src1};
  assign mul_b      = {{DATA_W{mul_signed & src2[DATA_W-1]}}, src2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_last   = mul_pipe_q[MUL_STAGES-1];

  assign sgn_op  = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign a_mag   = (sgn_op && a_q[DATA_W-1]) ? -a_q : a_q;
  assign b_mag   = (sgn_op && b_q[DATA_W-1]) ? -b_q : b_q;
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_RSV || div_zero) state_d = S_DONE;
          else if (div_op)              state_d = S_DIV_PREP;
          else                          state_d = S_MUL;
        end
      end
      S_MUL:      if (cnt_q == '0) state_d = S_DONE;
      S_DIV_PREP: state_d = S_DIV_ITER;
      S_DIV_ITER: if (cnt_q == '0) state_d = S_DIV_FIX;
      S_DIV_FIX:  state_d = S_DONE;
      S_DONE:     if (out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign result    = result_q;
  assign dbg_state = state_q;

  // Value written into result_q on the edge that enters DONE.
  always_comb begin
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (op == OP_RSV)                      result_d = '0;
        else if (op == OP_DIV || op == OP_DIVU) result_d = '1;
        else                                   result_d = src1;
      end
      S_MUL:     result_d = (op_q == OP_MUL) ? mul_last[DATA_W-1:0] : mul_last[2*DATA_W-1:DATA_W];
      S_DIV_FIX: result_d = (op_q == OP_DIV || op_q == OP_DIVU) ? quo_fix : rem_fix;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= src1;
        b_q  <= src2;
      end

      if (flush)
        cnt_q <= '0;
      else if (accept)
        cnt_q <= (div_op || op == OP_RSV) ? '0 : CNT_W'(MUL_STAGES - 1);
      else if (state_q == S_DIV_PREP)
        cnt_q <= CNT_W'(DATA_W - 1);
      else if ((state_q == S_MUL || state_q == S_DIV_ITER) && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;

      if (state_q == S_DIV_PREP) begin
        quo_q   <= a_mag;
        rem_q   <= '0;
        dvs_q   <= b_mag;
        q_neg_q <= sgn_op && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        r_neg_q <= sgn_op && a_q[DATA_W-1];
      end else if (state_q == S_DIV_ITER) begin
        // Restoring step: keep the trial subtraction only when it did not go negative.
        if (!diff[DATA_W]) begin
          rem_q <= diff[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], 1'b0};
        end
      end

      if (state_d == S_DONE && state_q != S_DONE)
        result_q <= result_d;
    end
  end

  // Multiplier output registers; stage 0 captures the array output at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe_q[i] <= '0;
    end else begin
      if (accept) mul_pipe_q[0] <= mul_prod;
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

endmodule
